// File: rtl/iir_fpu_sequencer_if.sv
// iir_fpu_sequencer_if: sample/coefficient handshake and shared FPU bus of the IIR sequencer.
// master is the sequencer side, slave is the sample source/sink plus FPU side.
interface iir_fpu_sequencer_if #(parameter int N_BITS = 32);
  logic [N_BITS-1:0] x_i, b0, b1, a, y_o;
  logic [N_BITS-1:0] mul_op_a_o, mul_op_b_o, mul_p_i, add_op_a_o, add_op_b_o, add_s_i;
  logic x_valid_i, x_ready_o, clr_i, y_valid_o, y_ready_i;
  logic mul_start_o, mul_done_i, add_start_o, add_done_i, err_o;
  modport master (
    input  x_i, x_valid_i, b0, b1, a, clr_i, y_ready_i, mul_done_i, mul_p_i, add_done_i, add_s_i,
    output x_ready_o, y_o, y_valid_o, mul_op_a_o, mul_op_b_o, mul_start_o,
           add_op_a_o, add_op_b_o, add_start_o, err_o
  );
  modport slave (
    output x_i, x_valid_i, b0, b1, a, clr_i, y_ready_i, mul_done_i, mul_p_i, add_done_i, add_s_i,
    input  x_ready_o, y_o, y_valid_o, mul_op_a_o, mul_op_b_o, mul_start_o,
           add_op_a_o, add_op_b_o, add_start_o, err_o
  );
endinterface

// File: rtl/iir_fpu_sequencer.sv
// iir_fpu_sequencer: y = b0*x + b1*x_prev + a*y_prev on one shared external FP multiplier and adder.
// Optional FPU watchdog enabled by IIR_SEQ_TIMEOUT_EN.
module iir_fpu_sequencer #(
  parameter int N_BITS  = 32,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  iir_fpu_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, M0, M1, A0, M2, A1, OUT} state_t;
  state_t state_q;
  logic [N_BITS-1:0] x_q, b1_q, a_q, xp_q, yp_q, r_q;
  logic in_mul, in_add, hit;
  assign in_mul = state_q inside {M0, M1, M2};
  assign in_add = state_q inside {A0, A1};
  // a done coinciding with our own start pulse belongs to an earlier request
  assign hit = ((in_mul && bus.mul_done_i) || (in_add && bus.add_done_i)) &&
               !bus.mul_start_o && !bus.add_start_o;
`ifdef IIR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic expired;
  assign expired = (in_mul || in_add) && !hit && tmo_q == TW'(TIMEOUT - 1);
`else
  assign bus.err_o = (TIMEOUT < 0);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= IDLE;
      x_q             <= '0;
      b1_q            <= '0;
      a_q             <= '0;
      xp_q            <= '0;
      yp_q            <= '0;
      r_q             <= '0;
      bus.x_ready_o   <= 1'b1;
      bus.y_o         <= '0;
      bus.y_valid_o   <= 1'b0;
      bus.mul_op_a_o  <= '0;
      bus.mul_op_b_o  <= '0;
      bus.mul_start_o <= 1'b0;
      bus.add_op_a_o  <= '0;
      bus.add_op_b_o  <= '0;
      bus.add_start_o <= 1'b0;
`ifdef IIR_SEQ_TIMEOUT_EN
      tmo_q           <= '0;
      bus.err_o       <= 1'b0;
`endif
    end else begin
      bus.mul_start_o <= 1'b0;
      bus.add_start_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clr_i) begin
            xp_q <= '0;
            yp_q <= '0;
          end
          if (bus.x_valid_i) begin
            x_q             <= bus.x_i;
            b1_q            <= bus.b1;
            a_q             <= bus.a;
            bus.mul_op_a_o  <= bus.x_i;
            bus.mul_op_b_o  <= bus.b0;
            bus.mul_start_o <= 1'b1;
            bus.x_ready_o   <= 1'b0;
            state_q         <= M0;
          end
        end
        M0: if (hit) begin
          r_q             <= bus.mul_p_i;
          bus.mul_op_a_o  <= xp_q;
          bus.mul_op_b_o  <= b1_q;
          bus.mul_start_o <= 1'b1;
          state_q         <= M1;
        end
        M1: if (hit) begin
          bus.add_op_a_o  <= r_q;
          bus.add_op_b_o  <= bus.mul_p_i;
          bus.add_start_o <= 1'b1;
          state_q         <= A0;
        end
        A0: if (hit) begin
          r_q             <= bus.add_s_i;
          bus.mul_op_a_o  <= yp_q;
          bus.mul_op_b_o  <= a_q;
          bus.mul_start_o <= 1'b1;
          state_q         <= M2;
        end
        M2: if (hit) begin
          bus.add_op_a_o  <= r_q;
          bus.add_op_b_o  <= bus.mul_p_i;
          bus.add_start_o <= 1'b1;
          state_q         <= A1;
        end
        A1: if (hit) begin
          r_q     <= bus.add_s_i;
          state_q <= OUT;
        end
        OUT: begin
          if (!bus.y_valid_o) begin
            bus.y_o       <= r_q;
            bus.y_valid_o <= 1'b1;
          end else if (bus.y_ready_i) begin
            xp_q          <= x_q;
            yp_q          <= bus.y_o;
            bus.y_valid_o <= 1'b0;
            bus.x_ready_o <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef IIR_SEQ_TIMEOUT_EN
      tmo_q <= ((in_mul || in_add) && !hit) ? tmo_q + 1'b1 : '0;
      if (expired) begin
        bus.err_o     <= 1'b1;
        bus.x_ready_o <= 1'b1;
        state_q       <= IDLE;
      end
`endif
    end
endmodule

// File: tb/tb_iir_fpu_sequencer.sv
// tb_iir_fpu_sequencer: scoreboard bench with latency-programmable FPU models.
// Build with +define+IIR_SEQ_TIMEOUT_EN to add the watchdog scenario.
`timescale 1ns/1ps
module tb_iir_fpu_sequencer;
  localparam logic [31:0] HALF = 32'h3F000000;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] JUNK = 32'h40400000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  iir_fpu_sequencer_if #(.N_BITS(32)) bus ();
  iir_fpu_sequencer #(.N_BITS(32), .TIMEOUT(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, fails = 0;
  int cyc = 0, nmul = 0, acc_cyc = 0;
  int lm = 2, la = 1, mcnt = 0, acnt = 0;
  bit mul_en = 1'b1, stray_m = 1'b0;
  logic [31:0] mres = '0, ares = '0;
  logic [31:0] exp_q[$];
  logic [31:0] mxp = '0, myp = '0, pend_x = '0, last_y = '0;
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    d = (s[30:0] == '0) ? {s[31], 63'b0} : {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    return (d[62:0] == '0) ? {d[63], 31'b0} : {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic int lat(input int m, input int a);
    return 3 * (m + 1) + 2 * (a + 1) + 1;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mul_start_o) nmul <= nmul + 1;
    if (!rst_n) mcnt <= 0;
    else if (bus.mul_start_o) begin
      mcnt <= lm;
      mres <= r2s(s2r(bus.mul_op_a_o) * s2r(bus.mul_op_b_o));
    end else if (mcnt > 0) mcnt <= mcnt - 1;
    if (!rst_n) acnt <= 0;
    else if (bus.add_start_o) begin
      acnt <= la;
      ares <= r2s(s2r(bus.add_op_a_o) + s2r(bus.add_op_b_o));
    end else if (acnt > 0) acnt <= acnt - 1;
  end
  assign bus.mul_done_i = (mul_en && mcnt == 1) || stray_m;
  assign bus.mul_p_i    = mres;
  assign bus.add_done_i = (acnt == 1);
  assign bus.add_s_i    = ares;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_x_ready"}, 32'(bus.x_ready_o), 1);
    check({tag, "_y_valid"}, 32'(bus.y_valid_o), 0);
    check({tag, "_y_o"}, bus.y_o, 0);
    check({tag, "_mul_start"}, 32'(bus.mul_start_o), 0);
    check({tag, "_add_start"}, 32'(bus.add_start_o), 0);
    check({tag, "_mul_ops"}, bus.mul_op_a_o | bus.mul_op_b_o, 0);
    check({tag, "_add_ops"}, bus.add_op_a_o | bus.add_op_b_o, 0);
    check({tag, "_err"}, 32'(bus.err_o), 0);
  endtask
  // drive one sample, push its expected output, then disturb clr/coefficients while in flight
  task automatic send(input logic [31:0] x, b0, b1, a, input bit clr);
    int n = 0;
    @(negedge clk);
    while (!bus.x_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.x_ready_o) begin
      check("x_ready_wait", 32'(bus.x_ready_o), 1);
      return;
    end
    bus.x_i = x; bus.b0 = b0; bus.b1 = b1; bus.a = a;
    bus.x_valid_i = 1'b1; bus.clr_i = clr;
    @(negedge clk);
    acc_cyc = cyc;
    bus.x_valid_i = 1'b0;
    bus.x_i = JUNK; bus.b0 = JUNK; bus.b1 = JUNK; bus.a = JUNK;
    bus.clr_i = 1'b1;
    if (clr) begin
      mxp = '0;
      myp = '0;
    end
    exp_q.push_back(r2s(s2r(b0) * s2r(x) + s2r(b1) * s2r(mxp) + s2r(a) * s2r(myp)));
    pend_x = x;
    @(negedge clk);
    bus.clr_i = 1'b0;
  endtask
  task automatic recv(input int exp_lat, input int hold);
    int n = 0;
    bit bad = 1'b0;
    logic [31:0] e, y0;
    bus.y_ready_i = (hold == 0);
    while (!bus.y_valid_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.y_valid_o) begin
      check("y_valid_wait", 32'(bus.y_valid_o), 1);
      bus.y_ready_i = 1'b1;
      return;
    end
    check("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("y", bus.y_o, e);
    y0 = bus.y_o;
    last_y = bus.y_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.y_o !== y0 || bus.x_ready_o || !bus.y_valid_o || bus.mul_start_o || bus.add_start_o) bad = 1'b1;
    end
    if (hold > 0) begin
      check("backpressure_hold", 32'(bad), 0);
      bus.y_ready_i = 1'b1;
    end
    @(negedge clk);
    check("release_x_ready", 32'(bus.x_ready_o), 1);
    check("release_y_valid", 32'(bus.y_valid_o), 0);
    mxp = pend_x;
    myp = e;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, m0;
    bus.x_i = '0; bus.b0 = '0; bus.b1 = '0; bus.a = '0;
    bus.x_valid_i = 1'b0; bus.clr_i = 1'b0; bus.y_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(2, 1), 0);
    check("y1_const", last_y, 32'h3F000000);
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(2, 1), 0);
    check("y2_const", last_y, 32'h3FA00000);
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(2, 1), 10);
    check("y3_const", last_y, 32'h3FD00000);
    @(negedge clk);
    stray_m = 1'b1;
    @(negedge clk);
    stray_m = 1'b0;
    @(negedge clk);
    check("stray_x_ready", 32'(bus.x_ready_o), 1);
    check("stray_starts", {30'b0, bus.mul_start_o, bus.add_start_o}, 0);
    check("stray_y_valid", 32'(bus.y_valid_o), 0);
    bus.clr_i = 1'b1;
    @(negedge clk);
    bus.clr_i = 1'b0;
    mxp = '0;
    myp = '0;
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(2, 1), 0);
    check("clr_const", last_y, 32'h3F000000);
    send(ONE, HALF, HALF, HALF, 1'b1);
    recv(lat(2, 1), 0);
    check("clr_accept_const", last_y, 32'h3F000000);
    lm = 1;
    la = 3;
    send(32'h40000000, 32'h3E800000, ONE, HALF, 1'b0);
    recv(lat(1, 3), 0);
    check("lat_mix_const", last_y, 32'h3FE00000);
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(1, 3), 0);
    lm = 2;
    la = 1;
    m0 = nmul;
    send(ONE, HALF, HALF, HALF, 1'b0);
    n = 0;
    while (nmul < m0 + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_m2", 32'(nmul - m0), 3);
    rst_n = 1'b0;
    #1;
    check_reset("midop_reset");
    exp_q.delete();
    mxp = '0;
    myp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(2, 1), 0);
    check("after_reset_const", last_y, 32'h3F000000);
`ifdef IIR_SEQ_TIMEOUT_EN
    mul_en = 1'b0;
    send(ONE, HALF, HALF, HALF, 1'b0);
    while (cyc < acc_cyc + 63) @(negedge clk);
    check("err_before_timeout", 32'(bus.err_o), 0);
    @(negedge clk);
    check("err_at_timeout", 32'(bus.err_o), 1);
    check("timeout_x_ready", 32'(bus.x_ready_o), 1);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.y_valid_o) n++;
    end
    check("timeout_no_y_valid", 32'(n), 0);
    void'(exp_q.pop_front());
    mul_en = 1'b1;
    send(ONE, HALF, HALF, HALF, 1'b0);
    recv(lat(2, 1), 0);
    check("err_sticky", 32'(bus.err_o), 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
